// File: rtl/requant_shift_sat.sv
// requant_shift_sat: per-channel requantization of convolution accumulators.
// Three-stage valid/ready pipeline:
//   S1 bias add, S2 exact multiply, S3 shift / zero-point add / saturate.
// Build option: define REQUANT_ROUND_EN for round-half-up before the right
// shift. Without it the shift truncates toward -inf. Latency and ports are the
// same in both builds.
module requant_shift_sat #(
    parameter int unsigned ACC_W = 32,
    parameter int unsigned MUL_W = 16,
    parameter int unsigned OUT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [ACC_W-1:0] in_acc,
    input  logic signed [ACC_W-1:0] in_bias,
    input  logic signed [MUL_W-1:0] in_mult,
    input  logic        [4:0]       in_shift,
    input  logic signed [OUT_W-1:0] in_zp,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data
);

    // Widths chosen so that no intermediate can wrap.
    localparam int unsigned SUM_W  = ACC_W + 1;
    localparam int unsigned PROD_W = ACC_W + MUL_W + 1;
    localparam int unsigned Q_W    = PROD_W + 1;
    localparam int unsigned V_W    = Q_W + 1;

    localparam longint MaxOut = (longint'(1) <<< (OUT_W - 1)) - 1;
    localparam longint MinOut = -(longint'(1) <<< (OUT_W - 1));

    logic adv;

    // Stage 1 registers
    logic                    s1_valid_q;
    logic signed [SUM_W-1:0] s1_sum_q;
    logic signed [SUM_W-1:0] sum_d;
    logic signed [MUL_W-1:0] s1_mult_q;
    logic        [4:0]       s1_shift_q;
    logic signed [OUT_W-1:0] s1_zp_q;

    // Stage 2 registers
    logic                     s2_valid_q;
    logic signed [PROD_W-1:0] s2_prod_q;
    logic signed [PROD_W-1:0] prod_d;
    logic        [4:0]        s2_shift_q;
    logic signed [OUT_W-1:0]  s2_zp_q;

    // Stage 3 registers
    logic                    out_valid_q;
    logic signed [OUT_W-1:0] out_data_q;
    logic signed [OUT_W-1:0] sat_d;

    // Stage-3 intermediates
    logic signed [Q_W-1:0] q;
    logic signed [V_W-1:0] v;
`ifdef REQUANT_ROUND_EN
    logic signed [Q_W-1:0] r;
`endif

    // Whole pipeline moves as one unit; it only freezes when a finished beat is refused.
    always_comb begin
        adv      = !out_valid_q || out_ready;
        in_ready = adv;
    end

    // S1 datapath: sign-extended bias add at ACC_W+1 bits.
    always_comb begin
        sum_d = {in_acc[ACC_W-1], in_acc} + {in_bias[ACC_W-1], in_bias};
    end

    // Stage 1 register: sum plus the per-beat channel constants.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_sum_q   <= '0;
            s1_mult_q  <= '0;
            s1_shift_q <= '0;
            s1_zp_q    <= '0;
        end else if (adv) begin
            s1_valid_q <= in_valid;
            // Data only loads on real beats so bubbles do not toggle the datapath.
            if (in_valid) begin
                s1_sum_q   <= sum_d;
                s1_mult_q  <= in_mult;
                s1_shift_q <= in_shift;
                s1_zp_q    <= in_zp;
            end
        end
    end

    // S2 datapath: exact signed product, both operands widened first.
    always_comb begin
        prod_d = PROD_W'(s1_sum_q) * PROD_W'(s1_mult_q);
    end

    // Stage 2 register: product with shift and zero point carried along.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid_q <= 1'b0;
            s2_prod_q  <= '0;
            s2_shift_q <= '0;
            s2_zp_q    <= '0;
        end else if (adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                s2_prod_q  <= prod_d;
                s2_shift_q <= s1_shift_q;
                s2_zp_q    <= s1_zp_q;
            end
        end
    end

    // S3 datapath: optional rounding, arithmetic shift, zero-point add, full-width clamp.
    always_comb begin
`ifdef REQUANT_ROUND_EN
        r = Q_W'(s2_prod_q);
        // Round half up; a zero shift has no fractional bits to round.
        if (s2_shift_q != 5'd0) begin
            r = r + (Q_W'(1) << (s2_shift_q - 5'd1));
        end
        q = r >>> s2_shift_q;
`else
        q = Q_W'(s2_prod_q) >>> s2_shift_q;
`endif
        v = V_W'(q) + V_W'(s2_zp_q);
        // Compare the whole value; the low bits alone cannot reveal overflow.
        if (v > V_W'(MaxOut)) begin
            sat_d = OUT_W'(MaxOut);
        end else if (v < V_W'(MinOut)) begin
            sat_d = OUT_W'(MinOut);
        end else begin
            sat_d = v[OUT_W-1:0];
        end
    end

    // Stage 3 register: the output beat, held while downstream stalls.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else if (adv) begin
            out_valid_q <= s2_valid_q;
            if (s2_valid_q) begin
                out_data_q <= sat_d;
            end
        end
    end

    // Output drive
    always_comb begin
        out_valid = out_valid_q;
        out_data  = out_data_q;
    end

`ifndef SYNTHESIS
    // A refused beat must stay put until it is taken.
    a_hold_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid_q && !out_ready) |=> (out_valid_q && $stable(out_data_q)));
`endif

endmodule

// File: tb/tb_requant_shift_sat.sv
// Self-checking bench for requant_shift_sat: a reference model feeds a
// scoreboard queue at input acceptance, checked in order at output transfer.
`timescale 1ns/1ps
module tb_requant_shift_sat;

    localparam int ACC_W = 32;
    localparam int MUL_W = 16;
    localparam int OUT_W = 8;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic signed [ACC_W-1:0] in_acc;
    logic signed [ACC_W-1:0] in_bias;
    logic signed [MUL_W-1:0] in_mult;
    logic        [4:0]       in_shift;
    logic signed [OUT_W-1:0] in_zp;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [OUT_W-1:0] out_data;

    typedef struct {
        longint val;
        int     cyc;
        bit     lat;
    } exp_t;

    exp_t   sb[$];
    int     cyc       = 0;
    int     n_tests   = 0;
    int     n_fail    = 0;
    bit     chk_lat   = 1'b1;
    bit     held      = 1'b0;
    longint held_data = 0;

    requant_shift_sat #(
        .ACC_W(ACC_W),
        .MUL_W(MUL_W),
        .OUT_W(OUT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_acc   (in_acc),
        .in_bias  (in_bias),
        .in_mult  (in_mult),
        .in_shift (in_shift),
        .in_zp    (in_zp),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input longint got, input longint exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: wide integer arithmetic, floor division by 2^shift.
    function automatic longint model(input longint acc, input longint bias, input longint mult,
                                     input int sh, input longint zp);
        longint p;
        longint v;
        p = (acc + bias) * mult;
`ifdef REQUANT_ROUND_EN
        if (sh > 0) p = p + (longint'(1) << (sh - 1));
`endif
        v = (p >>> sh) + zp;
        if (v > 127) v = 127;
        else if (v < -128) v = -128;
        return v;
    endfunction

    // Monitor: stall stability, output scoreboard compare, input scoreboard push.
    always @(negedge clk) begin
        if (rst) begin
            held <= 1'b0;
        end else begin
            if (held) begin
                check_val("stall_valid", out_valid, 1);
                check_val("stall_data", out_data, held_data);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check_val("spurious_out", out_valid, 0);
                end else begin
                    check_val("data", out_data, sb[0].val);
                    if (sb[0].lat) check_val("latency", cyc - sb[0].cyc, 3);
                    void'(sb.pop_front());
                end
            end
            if (in_valid && in_ready) begin
                sb.push_back('{val: model(in_acc, in_bias, in_mult, int'(in_shift), in_zp),
                               cyc: cyc, lat: chk_lat});
            end
            held      <= out_valid && !out_ready;
            held_data <= out_data;
        end
    end

    task automatic send(input logic signed [ACC_W-1:0] acc, input logic signed [ACC_W-1:0] bias,
                        input logic signed [MUL_W-1:0] mult, input logic [4:0] sh,
                        input logic signed [OUT_W-1:0] zp);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_acc   = acc;
        in_bias  = bias;
        in_mult  = mult;
        in_shift = sh;
        in_zp    = zp;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check_val("send_timeout", ok, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 200) begin
            @(posedge clk);
            k++;
        end
        @(negedge clk);
        check_val("drain_empty", sb.size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_acc    = '0;
        in_bias   = '0;
        in_mult   = '0;
        in_shift  = '0;
        in_zp     = '0;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_val("rst_out_valid", out_valid, 0);
        check_val("rst_out_data", out_data, 0);
        check_val("rst_in_ready", in_ready, 1);
        #2 rst = 1'b0;
        @(posedge clk);
        #1;

        // Scaling path: (300-44)*3 >> 4 - 10 = 38
        send(32'sd300, -32'sd44, 16'sd3, 5'd4, -8'sd10);
        drain();

        // Saturation at both ends, and the extreme sum with no wrap
        send(32'sd1000, 32'sd0, 16'sd1, 5'd0, 8'sd0);
        send(-32'sd1000, 32'sd0, 16'sd1, 5'd0, 8'sd0);
        send(32'sh7FFFFFFF, 32'sh7FFFFFFF, 16'sh7FFF, 5'd0, 8'sd0);
        send(-32'sh80000000, -32'sh80000000, 16'sh7FFF, 5'd31, 8'sd0);
        drain();

        // Rounding boundary: +-5 / 2
        send(32'sd5, 32'sd0, 16'sd1, 5'd1, 8'sd0);
        send(-32'sd5, 32'sd0, 16'sd1, 5'd1, 8'sd0);
        drain();

        // Random back-to-back beats, unstalled
        for (int i = 0; i < 16; i++) begin
            send($urandom, $urandom, 16'($urandom), 5'($urandom_range(0, 31)),
                 8'($urandom));
        end
        drain();

        // Backpressure: out_ready held low for 6 cycles while streaming 1..6
        chk_lat   = 1'b0;
        out_ready = 1'b0;
        fork
            begin
                for (int i = 1; i <= 6; i++) send(32'(i), 32'sd0, 16'sd1, 5'd0, 8'sd0);
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    if (i >= 3) begin
                        check_val("bp_in_ready", in_ready, 0);
                        check_val("bp_out_data", out_data, 1);
                    end
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    check_val("bp_no_gap", out_valid, 1);
                end
            end
        join
        drain();

        // Random backpressure with random small-range data
        fork
            begin
                for (int i = 0; i < 20; i++) begin
                    send(32'($urandom_range(0, 4000)) - 32'sd2000, 32'($urandom_range(0, 200)),
                         16'($urandom_range(0, 60)) - 16'sd30, 5'($urandom_range(0, 6)),
                         8'($urandom));
                    if (($urandom & 3) == 0) idle(1);
                end
            end
            begin
                repeat (40) begin
                    @(posedge clk);
                    #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drain();

        // Bubbles between beats, then continuous stream
        chk_lat = 1'b1;
        send(32'sd10, 32'sd0, 16'sd1, 5'd0, 8'sd0);
        idle(1);
        send(32'sd20, 32'sd0, 16'sd1, 5'd0, 8'sd0);
        idle(1);
        send(32'sd30, 32'sd0, 16'sd1, 5'd0, 8'sd0);
        drain();
        for (int i = 1; i <= 5; i++) send(32'(i * 11), 32'sd0, 16'sd1, 5'd0, 8'sd0);
        drain();

        // Reset with beats in flight
        out_ready = 1'b0;
        send(32'sd100, 32'sd0, 16'sd1, 5'd0, 8'sd0);
        send(32'sd200, 32'sd0, 16'sd1, 5'd0, 8'sd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (out_valid) break;
        end
        check_val("pre_rst_valid", out_valid, 1);
        #2 rst = 1'b1;
        #1;
        check_val("rst_mid_valid", out_valid, 0);
        check_val("rst_mid_data", out_data, 0);
        sb.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_val("post_rst_quiet", out_valid, 0);
        @(posedge clk);
        #1;
        send(32'sd7, 32'sd0, 16'sd1, 5'd0, 8'sd0);
        drain();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
